// File: rtl/oled_spi_tx.sv
// oled_spi_tx: byte-wide SPI write engine for the SSD1306 PmodOLED.
// Bytes tagged with a D/C flag are queued in a small FIFO, then sent MSB-first
// on sdo/sclk. The dc line is held for the whole byte and keeps its value
// between bytes.
module oled_spi_tx #(
    parameter int clkdiv = 4,
    parameter int depth  = 4,
    parameter int aw     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_dc,
    output logic          full,
    output logic [aw:0]   count,
    output logic          sdo,
    output logic          sclk,
    output logic          dc,
    output logic          done,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP} state_t;

    localparam logic [7:0]  div_last_val = 8'(clkdiv - 1);
    localparam logic [aw:0] full_lvl     = (aw + 1)'(depth);

    logic [8:0]    mem [depth];
    logic [8:0]    head;
    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic [7:0]    shreg;
    logic [7:0]    div;
    logic [2:0]    bitidx;
    logic          push;
    logic          pop;
    logic          div_last;
    logic          last_bit;
    state_t        state;
    state_t        state_nx;

    assign full     = (count == full_lvl);
    assign push     = wr_en && !full;
    assign head     = mem[rptr];
    assign div_last = (div == div_last_val);
    assign last_bit = (bitidx == 3'd0);

    // FIFO storage; entries are {dc, data} and need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {wr_dc, wr_data};
    end

    // FIFO pointers and occupancy; a push and a pop in one cycle cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + aw'(1);
            if (pop)  rptr <= rptr + aw'(1);
            case ({push, pop})
                2'b10:   count <= count + (aw + 1)'(1);
                2'b01:   count <= count - (aw + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Shifter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; sclk is low only in LOW, so it idles high
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        sclk     = 1'b1;
        case (state)
            IDLE: if (count != '0) state_nx = LOAD;
            LOAD: begin
                pop      = 1'b1;
                state_nx = LOW;
            end
            LOW: begin
                sclk = 1'b0;
                if (div_last) state_nx = HIGH;
            end
            HIGH: if (div_last) state_nx = last_bit ? GAP : LOW;
            GAP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Serial control: sdo moves only in LOAD or at the HIGH->LOW boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdo    <= 1'b0;
            dc     <= 1'b0;
            done   <= 1'b0;
            bitidx <= 3'd7;
            div    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    dc     <= head[8];
                    sdo    <= head[7];
                    bitidx <= 3'd7;
                    div    <= '0;
                end
                LOW: div <= div_last ? '0 : div + 8'd1;
                HIGH: begin
                    div <= div_last ? '0 : div + 8'd1;
                    if (div_last) begin
                        if (last_bit) begin
                            done <= 1'b1;
                        end else begin
                            bitidx <= bitidx - 3'd1;
                            sdo    <= shreg[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift register contents (pure data path)
    always_ff @(posedge clk) begin
        if (state == LOAD)
            shreg <= head[7:0];
        else if (state == HIGH && div_last && !last_bit)
            shreg <= {shreg[6:0], 1'b0};
    end

    // Registered busy: covers both a pending FIFO entry and an active byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= 1'b0;
        else      busy <= (state != IDLE) || (count != '0);
    end

endmodule
